// File: rtl/tail_light_pkg.sv
// Shared types and pattern helpers for the tail-light turn-signal path.
// Pure decode functions: state to mode, mode to entry state, step order, lamp patterns.
package tail_light_pkg;

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, L0, R1, R2, R3, R0, HON, HOFF
  } state_t;

  typedef enum logic [1:0] {
    OFF, LEFT, RIGHT, HAZ
  } mode_t;

  localparam logic [2:0] PAT_OFF = 3'b000;
  localparam logic [2:0] PAT_1   = 3'b001;
  localparam logic [2:0] PAT_2   = 3'b011;
  localparam logic [2:0] PAT_3   = 3'b111;

  function automatic mode_t state_mode(input state_t s);
    case (s)
      L1, L2, L3, L0: return LEFT;
      R1, R2, R3, R0: return RIGHT;
      HON, HOFF:      return HAZ;
      default:        return OFF;
    endcase
  endfunction

  function automatic state_t entry_state(input mode_t m);
    case (m)
      LEFT:    return L1;
      RIGHT:   return R1;
      HAZ:     return HON;
      default: return IDLE;
    endcase
  endfunction

  function automatic state_t step_state(input state_t s);
    case (s)
      L1:      return L2;
      L2:      return L3;
      L3:      return L0;
      L0:      return L1;
      R1:      return R2;
      R2:      return R3;
      R3:      return R0;
      R0:      return R1;
      HON:     return HOFF;
      HOFF:    return HON;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [2:0] left_pattern(input state_t s);
    case (s)
      L1:      return PAT_1;
      L2:      return PAT_2;
      L3, HON: return PAT_3;
      default: return PAT_OFF;
    endcase
  endfunction

  function automatic logic [2:0] right_pattern(input state_t s);
    case (s)
      R1:      return PAT_1;
      R2:      return PAT_2;
      R3, HON: return PAT_3;
      default: return PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/turn_signal_sequencer_if.sv
// Lever/switch requests in, left/right 3-lamp patterns out toward the brake-light stage.
interface turn_signal_sequencer_if;
  logic       left;
  logic       right;
  logic       hazard;
  logic [2:0] l_signal;
  logic [2:0] r_signal;

  modport master (output left, right, hazard, input l_signal, r_signal);
  modport slave  (input left, right, hazard, output l_signal, r_signal);
endinterface

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser for asynchronous level inputs.
module sync_2ff (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  // NOTE: non-blocking assignments make the two flops shift in parallel; blocking would collapse them into one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/turn_signal_sequencer.sv
// Sequential turn-signal / hazard pattern generator: synchronisers, mode decode,
// step prescaler and a Moore FSM with registered lamp outputs.
module turn_signal_sequencer
  import tail_light_pkg::*;
#(
  parameter int unsigned STEP_DIV = 12_500_000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  turn_signal_sequencer_if.slave  bus
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic left_s, right_s, hazard_s;

  sync_2ff u_sync_left   (.clock(clock), .reset_n(reset_n), .d(bus.left),   .q(left_s));
  sync_2ff u_sync_right  (.clock(clock), .reset_n(reset_n), .d(bus.right),  .q(right_s));
  sync_2ff u_sync_hazard (.clock(clock), .reset_n(reset_n), .d(bus.hazard), .q(hazard_s));

  mode_t            mode;
  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mode_change;
  logic             tick;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mode = OFF;
    if (hazard_s || (left_s && right_s)) mode = HAZ;
    else if (left_s)                     mode = LEFT;
    else if (right_s)                    mode = RIGHT;
  end

  assign mode_change = (mode != state_mode(state));
  assign tick        = (cnt == CNT_MAX);

  // Step timing restarts at every mode entry, so the first pattern lasts a full step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                  cnt <= '0;
    else if ((mode == OFF) || mode_change || tick) cnt <= '0;
    else                                           cnt <= cnt + CNT_W'(1);
  end

  always_comb begin
    state_next = state;
    if (mode_change) state_next = entry_state(mode);
    else if (tick)   state_next = step_state(state);
  end

  // Lamp registers load the decode of the next state, so they always match the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.l_signal <= PAT_OFF;
      bus.r_signal <= PAT_OFF;
    end else begin
      state        <= state_next;
      bus.l_signal <= left_pattern(state_next);
      bus.r_signal <= right_pattern(state_next);
    end
  end

endmodule

// File: doc/turn_signal_sequencer.md
# turn_signal_sequencer

- Generates the sequential left/right turn-signal and hazard patterns for the tail-light path.
- Sits directly upstream of the brake-light stage and drives its `l_signal[2:0]` and `r_signal[2:0]` inputs.
- Converts raw lever/switch inputs into stepped 3-lamp patterns using a clock prescaler and a Moore state machine.
- Does not handle braking; the downstream stage overlays brake behaviour onto these patterns.

## Interface
- `STEP_DIV`, default 12_500_000: clock cycles per pattern step (0.25 s at 50 MHz). Must be ≥ 2.
- `clock`, input, 1: single system clock, rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `left`, input, 1: left turn request. Asynchronous to `clock`, level-sensitive.
- `right`, input, 1: right turn request. Asynchronous, level-sensitive.
- `hazard`, input, 1: hazard request. Asynchronous, level-sensitive.
- `l_signal`, output, 3: left lamp pattern; bit0 is innermost, bit2 outermost.
- `r_signal`, output, 3: right lamp pattern; bit0 is innermost, bit2 outermost.

## Operation
- **Input synchronisers:** `left`, `right` and `hazard` each pass through a 2-flop synchroniser. The FSM uses only the synchronised copies.
- **Mode decode (combinational, from synchronised inputs):**
  - HAZ if `hazard`, or if `left` and `right` are both set.
  - LEFT if only `left` is set.
  - RIGHT if only `right` is set.
  - OFF otherwise.
- **Prescaler:**
  - Counter width is `$clog2(STEP_DIV)`. It counts 0 to STEP_DIV-1 and wraps.
  - `tick` is a 1-cycle pulse when count == STEP_DIV-1.
  - The counter is held at 0 in mode OFF and is cleared on any mode change.
- **FSM states and outputs (Moore):**
  - IDLE: both outputs 000.
  - L1: l=001. L2: l=011. L3: l=111. L0: l=000. In all L states, r=000.
  - R1 to R0 mirror L1 to L0 on `r_signal`, with l=000.
  - HON: l=111, r=111. HOFF: l=000, r=000.
- **Transitions, in priority order:**
  1. If the synchronised mode differs from the mode of the current state (IDLE belongs to OFF), go next edge to the entry state of the new mode: OFF→IDLE, LEFT→L1, RIGHT→R1, HAZ→HON. This happens regardless of `tick`.
  2. Otherwise, on `tick`:
     - L1→L2→L3→L0→L1.
     - R1→R2→R3→R0→R1.
     - HON→HOFF→HON.
  3. Otherwise, hold state.
- **Mode changes mid-sequence:** abandon immediately, with no sequence completion. A left→right change goes directly to R1, never through IDLE.

## Timing
- **Reset:** `reset_n` low clears everything asynchronously: state=IDLE, `l_signal`=000, `r_signal`=000, prescaler=0, synchroniser flops=0. Release is synchronous in effect; the first state change can occur no earlier than 3 edges after release.
- **Request latency:** an input change that is stable before edge 0 is captured at edges 0 and 1 and enters the FSM at edge 2. The new entry pattern is visible on the outputs after edge 2. Latency is 3 edges.
- **Step period:** exactly STEP_DIV cycles between pattern changes, measured from mode entry.
  - L1 is shown for STEP_DIV cycles, then L2, and so on.
  - A full left/right cycle takes 4×STEP_DIV cycles.
  - A full hazard cycle takes 2×STEP_DIV cycles.
- **Simultaneous events:**
  - A mode change and `tick` in the same cycle: the mode change wins, and the prescaler restarts at 0.
  - A `left`/`right` transition from 10 to 11 counts as a mode change to HAZ.
- **Glitches:** request pulses shorter than one clock period may be lost. Pulses of two or more cycles are always seen.
- **Outputs:** decoded only from the state register. No combinational path from the inputs, and no glitching on step boundaries.
- **Reset mid-sequence:** outputs go to 000 immediately, without waiting for a clock edge.

## Structure
- **Package `tail_light_pkg`** holds:
  - the state enum: IDLE, L1, L2, L3, L0, R1, R2, R3, R0, HON, HOFF;
  - the mode enum: OFF, LEFT, RIGHT, HAZ;
  - pattern constants PAT_OFF=000, PAT_1=001, PAT_2=011, PAT_3=111.
- **Sub-module `sync_2ff`:** one-bit 2-flop synchroniser with async active-low reset. Instantiated three times.
- **Top-level:** prescaler, mode decode, FSM and output decode live in the top-level module.

## Test plan
All scenarios use STEP_DIV=4 for simulation.
- **Reset:** assert `reset_n`=0 mid-sequence (state L2) → outputs 000 with no clock edge; after release with no inputs, they stay 000.
- **Left sequence:** hold `left`=1 → after 3 edges l=001. Then every 4 cycles l steps 011, 111, 000, 001; r=000 throughout.
- **Right then drop:** hold `right` until r=011, then drop it → r=000 exactly 3 edges after the drop, with no further steps.
- **Left→right switch:** switch at l=111 → 3 edges later l=000, r=001; the next step comes 4 cycles after that.
- **Hazard:** `hazard`=1 alone, or `left`=`right`=1 → both outputs 111 for 4 cycles, then 000 for 4 cycles, repeating. Dropping `hazard` while `left` is held enters L1.
- **Tick collision:** change mode on the same cycle the prescaler reaches 3 → the entry pattern appears, and the next step comes a full 4 cycles later.
